// File: rtl/countdown_w_autoreload.sv
// Programmable down-counter with one-shot or periodic auto-reload.
// Emits a one-cycle terminal-count pulse each time the count expires.
module countdown_w_autoreload #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] reload_value,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_d;
    logic [WIDTH-1:0] value_d;
    logic             tc_d;
    logic             terminal;

    // Last enabled cycle of a count: value is leaving 1.
    assign terminal = (state == RUN) && en && (value == ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode: load beats stop beats counting.
    always_comb begin
        state_d = state;
        if (load) begin
            state_d = (reload_value != ZERO) ? RUN : IDLE;
        end else if (state == RUN) begin
            if (stop) begin
                state_d = IDLE;
            end else if (terminal && !periodic) begin
                state_d = IDLE;
            end
        end
    end

    // Next count, reload register and terminal pulse.
    always_comb begin
        value_d  = value;
        reload_d = reload_reg;
        tc_d     = 1'b0;
        if (load) begin
            value_d  = reload_value;
            reload_d = reload_value;
        end else if (state == RUN && !stop && en) begin
            if (value == ONE) begin
                tc_d    = 1'b1;
                value_d = periodic ? reload_reg : ZERO;
            end else if (value != ZERO) begin
                value_d = value - ONE;
            end
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            value      <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
        end else begin
            value      <= value_d;
            reload_reg <= reload_d;
            tc         <= tc_d;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_w_autoreload.sv
// Scoreboard bench for countdown_w_autoreload: directed scenarios
// followed by random stimulus, checked against a behavioural model.
module tb_countdown_w_autoreload;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] reload_value = 8'd0;
    logic [7:0] value;
    logic       tc;
    logic       busy;

    typedef struct packed {
        logic [7:0] value;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_tc_exp = 0;

    // behavioural model state
    bit       m_run = 0;
    int       m_val = 0;
    int       m_rel = 0;

    countdown_w_autoreload #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .stop(stop),
        .periodic(periodic),
        .reload_value(reload_value),
        .value(value),
        .tc(tc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, predict, queue expectation after posedge.
    task automatic cyc(input bit r, input bit l, input bit s, input bit e,
                       input bit p, input int rv);
        exp_t x;
        bit   t;
        @(negedge clk);
        rst = r; load = l; stop = s; en = e; periodic = p;
        reload_value = 8'(rv);
        t = 0;
        if (r) begin
            m_run = 0; m_val = 0; m_rel = 0;
        end else if (l) begin
            m_rel = rv; m_val = rv; m_run = (rv != 0);
        end else if (m_run && s) begin
            m_run = 0;
        end else if (m_run && e) begin
            if (m_val == 1) begin
                t = 1;
                if (p) m_val = m_rel;
                else begin m_val = 0; m_run = 0; end
            end else begin
                m_val = m_val - 1;
            end
        end
        if (t) n_tc_exp++;
        x.value = 8'(m_val);
        x.tc = t;
        x.busy = m_run;
        @(posedge clk);
        #1 q.push_back(x);
    endtask

    // Monitor: pop and compare every expectation at the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                n_checks++;
                if (value !== x.value) begin
                    n_fail++;
                    $display("FAIL value: got %0d expected %0d at %0t",
                             value, x.value, $time);
                end
                n_checks++;
                if (tc !== x.tc) begin
                    n_fail++;
                    $display("FAIL tc: got %b expected %b at %0t",
                             tc, x.tc, $time);
                end
                n_checks++;
                if (busy !== x.busy) begin
                    n_fail++;
                    $display("FAIL busy: got %b expected %b at %0t",
                             busy, x.busy, $time);
                end
            end
        end
    end

    initial begin
        int tc_before;
        // 1: reset with load and en asserted
        cyc(1, 1, 0, 1, 0, 9);
        cyc(1, 1, 0, 1, 0, 9);
        // 2: one-shot from 5
        cyc(0, 1, 0, 0, 0, 5);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 0);
        // 3: periodic from 3, three pulses in nine enabled cycles
        cyc(0, 1, 0, 0, 1, 3);
        tc_before = n_tc_exp;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1, 0);
        // 4: periodic from 4 with en toggling
        cyc(0, 1, 0, 0, 1, 4);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, (i % 2) == 0, 1, 0);
        // 5: stop mid-count, en ignored in IDLE, then reload
        cyc(0, 1, 0, 0, 0, 6);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 2);
        cyc(0, 0, 0, 1, 0, 0);
        // 6: load overrides terminal event; load of zero
        cyc(0, 1, 0, 0, 0, 2);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 7);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        // boundaries: reload of 1 periodic, max reload, reset in RUN
        cyc(0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 1, 255);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        // random phase
        for (int i = 0; i < 600; i++) begin
            int rv;
            rv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 5));
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 75,
                $urandom_range(0, 1) == 1,
                rv);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     q.size());
        end
        if (tc_before < 0) $display("unused");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
